sync_fifo_param: RTL and testbench

Parametrised synchronous FIFO that replaces the fixed 8-bit `sync_fifo`. It has configurable data width and depth. It adds occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. It sits between same-clock producer and consumer blocks as the standard buffering primitive.

---
 rtl/sync_fifo_param_pkg.sv | 26 ++
 rtl/sync_fifo_param_if.sv | 34 +++
 rtl/sync_fifo_param_mem_2p.sv | 28 ++
 rtl/sync_fifo_param.sv | 123 ++++++++++++
 tb/tb_sync_fifo_param.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_param_pkg.sv
// sync_fifo_param_pkg: shared definitions for the parametrised synchronous FIFO.
//   - ptr_w():        address/pointer width for a given depth
//   - is_pow2():      depth legality helper used by the elaboration check
//   - FWFT_* consts:  read-mode selector values
package sync_fifo_param_pkg;

  localparam int FWFT_OFF = 0;  // registered read, one-cycle latency
  localparam int FWFT_ON  = 1;  // head word presented combinationally

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_ok(input int data_w, input int depth,
                                   input int af, input int ae, input int fwft);
    return (data_w >= 1) && is_pow2(depth) &&
           (af >= 1) && (af <= depth) &&
           (ae >= 0) && (ae <= depth - 1) &&
           ((fwft == FWFT_OFF) || (fwft == FWFT_ON));
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: producer/consumer bundle of the FIFO.
//   master: the surrounding logic (drives wr_en/wr_data/rd_en, sees status)
//   slave:  the FIFO itself
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic              full;
  logic              almost_full;
  logic [DATA_W-1:0] rd_data;
  logic              rd_en;
  logic              rd_valid;
  logic              empty;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_data, wr_en, rd_en,
    input  full, almost_full, rd_data, rd_valid, empty, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_data, wr_en, rd_en,
    output full, almost_full, rd_data, rd_valid, empty, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param_mem_2p.sv
// fifo_mem_2p: DEPTH x DATA_W register array, one synchronous write port and
// one asynchronous read port. No reset: contents survive FIFO reset.
//   clk   - write clock
//   we    - write enable, waddr/wdata - write address/data
//   raddr - read address, rdata - combinational read data (old data on a
//           same-edge write to the same address)
module fifo_mem_2p #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised same-clock FIFO.
//   clk, reset - clock and synchronous active-high reset
//   bus        - slave side of sync_fifo_param_if: write (wr_en/wr_data/full/
//                almost_full), read (rd_en/rd_data/rd_valid/empty/
//                almost_empty), occupancy count and sticky overflow/underflow.
// All status outputs are registered from the next-state count, so nothing
// combinational runs from wr_en/rd_en to a flag.
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = FWFT_OFF
) (
  input  logic                clk,
  input  logic                reset,
  sync_fifo_param_if.slave    bus
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = AW + 1;

  if (!params_ok(DATA_W, DEPTH, AF_LEVEL, AE_LEVEL, FWFT)) begin : g_bad_param
    $error("sync_fifo_param: illegal DATA_W/DEPTH/AF_LEVEL/AE_LEVEL/FWFT");
  end

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d, afull_q, afull_d;
  logic              empty_q, empty_d, aempty_q, aempty_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] mem_rd;
  logic              rd_acc, wr_acc;

  fifo_mem_2p #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (bus.wr_data),
    .raddr (rd_ptr_q),
    .rdata (mem_rd)
  );

  always_comb begin
    rd_acc = bus.rd_en & ~empty_q;
    // A read in the same cycle frees a slot, so a write into a full FIFO is
    // still accepted alongside it. On empty the read is refused: no write-through.
    wr_acc = bus.wr_en & (~full_q | rd_acc);

    wr_ptr_d = wr_ptr_q + AW'(wr_acc);
    rd_ptr_d = rd_ptr_q + AW'(rd_acc);

    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= CW'(AF_LEVEL));
    aempty_d = (count_d <= CW'(AE_LEVEL));

    ovf_d = ovf_q | (bus.wr_en & ~wr_acc);
    unf_d = unf_q | (bus.rd_en & empty_q);

    // Output register for registered-read mode; holds its value between pops.
    rd_valid_d = rd_acc;
    rd_data_d  = rd_acc ? mem_rd : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      afull_q    <= 1'b0;
      empty_q    <= 1'b1;
      aempty_q   <= 1'b1;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      afull_q    <= afull_d;
      empty_q    <= empty_d;
      aempty_q   <= aempty_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  if (FWFT == FWFT_ON) begin : g_fwft
    // Head word is shown while non-empty; forced to zero when empty so the
    // output matches its reset value instead of exposing stale memory.
    assign bus.rd_data  = empty_q ? '0 : mem_rd;
    assign bus.rd_valid = ~empty_q;
  end else begin : g_reg_rd
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
  end

  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.almost_full  = afull_q;
  assign bus.empty        = empty_q;
  assign bus.almost_empty = aempty_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: one registered-read and one FWFT instance share
// the same stimulus; a reference queue holds the expected FIFO contents.
module tb_sync_fifo_param;
  import sync_fifo_param_pkg::*;

  localparam int DW = 8, DP = 4, AF = 3, AE = 1;

  logic clk = 1'b0;
  logic reset;
  logic wr_en, rd_en;
  logic [DW-1:0] wr_data;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DP)) if0 ();
  sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DP)) if1 ();

  assign if0.wr_en = wr_en;  assign if0.rd_en = rd_en;  assign if0.wr_data = wr_data;
  assign if1.wr_en = wr_en;  assign if1.rd_en = rd_en;  assign if1.wr_data = wr_data;

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .AF_LEVEL(AF), .AE_LEVEL(AE),
                    .FWFT(FWFT_OFF)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .AF_LEVEL(AF), .AE_LEVEL(AE),
                    .FWFT(FWFT_ON))  dut1 (.clk(clk), .reset(reset), .bus(if1));

  int errors = 0;
  int checks = 0;

  // reference model
  logic [DW-1:0] sb[$];
  int            mcnt;
  bit            movf, munf;
  logic [DW-1:0] last0;

  // One clock of stimulus. The scoreboard is popped on an accepted read and
  // the popped word is compared with what each DUT presents.
  task automatic step(input bit we, input logic [DW-1:0] wd, input bit re);
    bit racc, wacc;
    logic [DW-1:0] exp_d;
    logic [8:0] exp_st, st0, st1;
    exp_d = '0;
    wr_en = we; wr_data = wd; rd_en = re;
    #1;
    if (mcnt != 0) begin
      checks++;
      if (if1.rd_data !== sb[0]) begin
        errors++;
        $display("FAIL fwft_head: got %h exp %h", if1.rd_data, sb[0]);
      end
    end
    racc = re && (mcnt != 0);
    wacc = we && ((mcnt != DP) || racc);
    if (we && !wacc) movf = 1'b1;
    if (re && mcnt == 0) munf = 1'b1;
    if (racc) exp_d = sb.pop_front();
    if (wacc) sb.push_back(wd);
    mcnt = mcnt + int'(wacc) - int'(racc);
    @(posedge clk); #1;
    exp_st = {3'(mcnt), mcnt == DP, mcnt >= AF, mcnt == 0, mcnt <= AE, movf, munf};
    st0 = {if0.count, if0.full, if0.almost_full, if0.empty, if0.almost_empty,
           if0.overflow, if0.underflow};
    st1 = {if1.count, if1.full, if1.almost_full, if1.empty, if1.almost_empty,
           if1.overflow, if1.underflow};
    checks++;
    if (st0 !== exp_st) begin
      errors++; $display("FAIL status_reg: got %b exp %b", st0, exp_st);
    end
    checks++;
    if (st1 !== exp_st) begin
      errors++; $display("FAIL status_fwft: got %b exp %b", st1, exp_st);
    end
    if (racc) last0 = exp_d;
    checks++;
    if (if0.rd_valid !== racc || if0.rd_data !== last0) begin
      errors++;
      $display("FAIL rd_out_reg: got v=%b d=%h exp v=%b d=%h",
               if0.rd_valid, if0.rd_data, racc, last0);
    end
    checks++;
    if (if1.rd_valid !== (mcnt != 0)) begin
      errors++; $display("FAIL rd_valid_fwft: got %b exp %b", if1.rd_valid, mcnt != 0);
    end
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset(input bit wr_during);
    reset = 1'b1; wr_en = wr_during; wr_data = 8'hEE; rd_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; wr_en = 1'b0;
    sb.delete(); mcnt = 0; movf = 1'b0; munf = 1'b0; last0 = '0;
    checks++;
    if ({if0.count, if0.empty, if0.almost_empty, if0.full, if0.almost_full,
         if0.overflow, if0.underflow, if0.rd_valid, if0.rd_data} !== {3'd0, 6'b110000, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_reg: got cnt=%0d e=%b ae=%b f=%b af=%b o=%b u=%b v=%b d=%h exp 0 1 1 0 0 0 0 0 00",
               if0.count, if0.empty, if0.almost_empty, if0.full, if0.almost_full,
               if0.overflow, if0.underflow, if0.rd_valid, if0.rd_data);
    end
    checks++;
    if ({if1.count, if1.empty, if1.overflow, if1.underflow, if1.rd_valid, if1.rd_data} !==
        {3'd0, 4'b1000, 8'h00}) begin
      errors++;
      $display("FAIL reset_fwft: got cnt=%0d e=%b o=%b u=%b v=%b d=%h exp 0 1 0 0 0 00",
               if1.count, if1.empty, if1.overflow, if1.underflow, if1.rd_valid, if1.rd_data);
    end
  endtask

  task automatic test_fill;
    logic [DW-1:0] vals [4] = '{8'h91, 8'h5B, 8'hFB, 8'h3C};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, vals[i], 1'b0);
      checks++;
      if (if0.count !== 3'(i + 1)) begin
        errors++; $display("FAIL fill_count: got %0d exp %0d", if0.count, i + 1);
      end
    end
    checks++;
    if ({if0.full, if0.almost_full, if0.almost_empty, if0.overflow} !== 4'b1100) begin
      errors++;
      $display("FAIL fill_flags: got f=%b af=%b ae=%b o=%b exp 1 1 0 0",
               if0.full, if0.almost_full, if0.almost_empty, if0.overflow);
    end
    checks++;
    if (if1.rd_data !== 8'h91 || if1.rd_valid !== 1'b1 || if0.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL fwft_first: got d=%h v1=%b v0=%b exp 91 1 0",
               if1.rd_data, if1.rd_valid, if0.rd_valid);
    end
  endtask

  task automatic test_overflow;
    step(1'b1, 8'hAA, 1'b0);
    checks++;
    if (if0.count !== 3'd4 || if0.overflow !== 1'b1 || if1.overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow: got cnt=%0d o0=%b o1=%b exp 4 1 1", if0.count, if0.overflow, if1.overflow);
    end
    step(1'b0, 8'h00, 1'b0);
    checks++;
    if (if0.overflow !== 1'b1) begin
      errors++; $display("FAIL overflow_sticky: got %b exp 1", if0.overflow);
    end
  endtask

  task automatic test_full_rw;
    step(1'b1, 8'h77, 1'b1);
    checks++;
    if (if0.count !== 3'd4 || if0.full !== 1'b1 || if0.rd_data !== 8'h91 || if0.rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_rw: got cnt=%0d f=%b d=%h v=%b exp 4 1 91 1",
               if0.count, if0.full, if0.rd_data, if0.rd_valid);
    end
    step(1'b0, 8'h00, 1'b0);
    checks++;
    if (if0.rd_valid !== 1'b0 || if0.rd_data !== 8'h91) begin
      errors++; $display("FAIL rd_valid_pulse: got v=%b d=%h exp 0 91", if0.rd_valid, if0.rd_data);
    end
  endtask

  task automatic test_drain_underflow;
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    checks++;
    if (if0.rd_data !== 8'h77 || if0.empty !== 1'b1 || if0.underflow !== 1'b0) begin
      errors++;
      $display("FAIL drain_last: got d=%h e=%b u=%b exp 77 1 0", if0.rd_data, if0.empty, if0.underflow);
    end
    step(1'b0, 8'h00, 1'b1);
    checks++;
    if (if0.underflow !== 1'b1 || if1.underflow !== 1'b1 || if0.count !== 3'd0 ||
        if0.rd_data !== 8'h77 || if0.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL underflow: got u0=%b u1=%b cnt=%0d d=%h v=%b exp 1 1 0 77 0",
               if0.underflow, if1.underflow, if0.count, if0.rd_data, if0.rd_valid);
    end
  endtask

  task automatic test_empty_rw;
    step(1'b1, 8'h12, 1'b1);
    checks++;
    if (if0.count !== 3'd1 || if0.rd_valid !== 1'b0 || if1.rd_data !== 8'h12) begin
      errors++;
      $display("FAIL empty_rw: got cnt=%0d v0=%b d1=%h exp 1 0 12", if0.count, if0.rd_valid, if1.rd_data);
    end
    step(1'b0, 8'h00, 1'b1);
    checks++;
    if (if0.rd_data !== 8'h12) begin
      errors++; $display("FAIL empty_rw_read: got %h exp 12", if0.rd_data);
    end
  endtask

  task automatic test_mid_reset;
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    step(1'b1, 8'h03, 1'b0);
    test_reset(1'b1);
    step(1'b1, 8'hC3, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    checks++;
    if (if0.rd_data !== 8'hC3 || if0.count !== 3'd0) begin
      errors++; $display("FAIL post_reset_read: got d=%h cnt=%0d exp c3 0", if0.rd_data, if0.count);
    end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'(8'h40 + i * 7), 1'b0);
      step(1'b0, 8'h00, 1'b1);
    end
  endtask

  task automatic test_back_to_back;
    step(1'b1, 8'hA0, 1'b0);
    step(1'b1, 8'hA1, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 8'($urandom_range(255)), 1'b1);
    for (int i = 0; i < 6; i++) step(1'($urandom_range(1)), 8'($urandom_range(255)), 1'($urandom_range(1)));
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    @(posedge clk); #1;
    test_reset(1'b0);
    test_fill();
    test_overflow();
    test_full_rw();
    test_drain_underflow();
    test_empty_rw();
    test_mid_reset();
    test_wrap();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
